memory_stage: RTL and testbench



---
 rtl/memory_stage.sv | 111 +++++++++++
 tb/tb_memory_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: M pipeline register plus byte-addressed data memory
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic        dmem_error
);

  localparam int AW = $clog2(MEM_BYTES);
  // Highest legal start address of an 8-byte word.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] R_NONE   = 4'd15;

  logic [7:0]    mem [MEM_BYTES];
  logic          is_read;
  logic          is_write;
  logic [63:0]   addr;
  logic [AW-1:0] idx;
  logic [63:0]   rd_word;
  logic          wr_en;

  // M pipeline register: reset and bubble insert a nop, stall holds.
  always_ff @(posedge clk) begin
    if (reset || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (!M_stall) begin
      M_stat  <= e_stat;
      M_icode <= e_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_dstM;
    end
  end

  // Decode access kind and address; ret/popq address the stack through valA.
  always_comb begin
    is_write = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
    is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
    addr     = (M_icode == I_RET || M_icode == I_POPQ) ? M_valA : M_valE;
  end

  // Range check is a full 64-bit unsigned compare so huge addresses never alias.
  always_comb begin
    dmem_error = (is_read || is_write) && (addr > LAST_ADDR);
    // Only in-range addresses reach the array; out-of-range ones are masked to 0.
    idx        = dmem_error ? '0 : addr[AW-1:0];
    wr_en      = is_write && !dmem_error && (M_stat == STAT_AOK) && !reset;
  end

  // Little-endian gather of eight consecutive bytes (unaligned allowed).
  always_comb begin
    rd_word = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  // Status and read data handed to the W register and forwarding paths.
  always_comb begin
    m_stat = dmem_error ? STAT_ADR : M_stat;
    m_valM = (is_read && !dmem_error) ? rd_word : 64'd0;
  end

  // Byte-wise little-endian store; memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage with a byte-level reference model
module tb_memory_stage;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_stall;
  logic        M_bubble;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic        dmem_error;

  int tests = 0;
  int fails = 0;

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_valM(m_valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } mreg_t;

  localparam mreg_t BUBBLE = '{stat: 3'd1, icode: 4'd1, cnd: 1'b0, vale: 64'd0,
                               vala: 64'd0, dste: 4'd15, dstm: 4'd15};

  mreg_t mr = BUBBLE;
  logic [7:0] mm [logic [63:0]];

  function automatic bit wr_of(logic [3:0] ic);
    return ic == 4'd4 || ic == 4'd8 || ic == 4'd10;
  endfunction

  function automatic bit rd_of(logic [3:0] ic);
    return ic == 4'd5 || ic == 4'd9 || ic == 4'd11;
  endfunction

  function automatic logic [63:0] addr_of(mreg_t r);
    return (r.icode == 4'd9 || r.icode == 4'd11) ? r.vala : r.vale;
  endfunction

  // A word fits only if its last byte lies inside memory; 65-bit sum cannot wrap.
  function automatic bit err_of(mreg_t r);
    logic [64:0] end_excl;
    end_excl = {1'b0, addr_of(r)} + 65'd8;
    return (rd_of(r.icode) || wr_of(r.icode)) && (end_excl > 65'(MB));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the M register and memory.
  task automatic check_all(input string tag);
    logic [63:0] a;
    logic [63:0] w;
    bit known;
    bit e;
    e = err_of(mr);
    chk({tag, ".M_stat"},  64'(M_stat),  64'(mr.stat));
    chk({tag, ".M_icode"}, 64'(M_icode), 64'(mr.icode));
    chk({tag, ".M_Cnd"},   64'(M_Cnd),   64'(mr.cnd));
    chk({tag, ".M_valE"},  M_valE,       mr.vale);
    chk({tag, ".M_valA"},  M_valA,       mr.vala);
    chk({tag, ".M_dstE"},  64'(M_dstE),  64'(mr.dste));
    chk({tag, ".M_dstM"},  64'(M_dstM),  64'(mr.dstm));
    chk({tag, ".dmem_error"}, 64'(dmem_error), 64'(e));
    chk({tag, ".m_stat"}, 64'(m_stat), e ? 64'd3 : 64'(mr.stat));
    if (rd_of(mr.icode) && !e) begin
      a = addr_of(mr);
      w = 64'd0;
      known = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (mm.exists(a + 64'(i))) w[8*i +: 8] = mm[a + 64'(i)];
        else known = 1'b0;
      end
      if (known) chk({tag, ".m_valM"}, m_valM, w);
    end else begin
      chk({tag, ".m_valM"}, m_valM, 64'd0);
    end
  endtask

  // Advance one clock: retire the model's M instruction, then load the model register.
  task automatic tick();
    logic [63:0] a;
    if (!reset && mr.stat == 3'd1 && wr_of(mr.icode) && !err_of(mr)) begin
      a = addr_of(mr);
      for (int i = 0; i < 8; i++) mm[a + 64'(i)] = mr.vala[8*i +: 8];
    end
    if (reset || M_bubble) mr = BUBBLE;
    else if (!M_stall) mr = '{stat: e_stat, icode: e_icode, cnd: e_Cnd, vale: e_valE,
                              vala: e_valA, dste: e_dstE, dstm: e_dstM};
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va);
    e_stat  = s;
    e_icode = ic;
    e_valE  = ve;
    e_valA  = va;
    e_Cnd   = 1'b0;
    e_dstE  = 4'd15;
    e_dstM  = 4'd15;
  endtask

  initial begin
    reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
    drive(3'd1, 4'd0, 64'd0, 64'd0);
    @(negedge clk);

    // Reset loads a bubble
    tick();
    chk("rst.M_icode", 64'(M_icode), 64'd1);
    chk("rst.M_dstE", 64'(M_dstE), 64'd15);
    chk("rst.M_dstM", 64'(M_dstM), 64'd15);
    chk("rst.M_stat", 64'(M_stat), 64'd1);
    chk("rst.m_valM", m_valM, 64'd0);
    chk("rst.dmem_error", 64'(dmem_error), 64'd0);
    reset = 1'b0;

    // Store then load, little-endian byte order
    drive(3'd1, 4'd4, 64'h10, 64'h1122334455667788);
    tick(); check_all("st");
    drive(3'd1, 4'd5, 64'h10, 64'd0);
    tick(); check_all("ld");
    chk("ld.value", m_valM, 64'h1122334455667788);
    drive(3'd1, 4'd5, 64'h0F, 64'd0);
    tick();
    chk("ld.byte10", 64'(m_valM[15:8]), 64'h88);

    // Push then pop
    drive(3'd1, 4'd10, 64'h3F8, 64'hDEAD);
    tick(); check_all("push");
    drive(3'd1, 4'd11, 64'h400, 64'h3F8);
    tick(); check_all("pop");
    chk("pop.value", m_valM, 64'hDEAD);
    chk("pop.stat", 64'(m_stat), 64'd1);

    // Boundary: last legal word, one past it, and a wrap-prone address
    drive(3'd1, 4'd4, 64'(MB - 8), 64'hCAFEF00D12345678);
    tick(); check_all("edge_ok");
    chk("edge_ok.err", 64'(dmem_error), 64'd0);
    drive(3'd1, 4'd4, 64'(MB - 7), 64'hFFFFFFFFFFFFFFFF);
    tick(); check_all("edge_bad");
    chk("edge_bad.err", 64'(dmem_error), 64'd1);
    chk("edge_bad.stat", 64'(m_stat), 64'd3);
    drive(3'd1, 4'd5, 64'hFFFFFFFFFFFFFFF8, 64'd0);
    tick(); check_all("wrap");
    chk("wrap.err", 64'(dmem_error), 64'd1);
    drive(3'd1, 4'd5, 64'(MB - 8), 64'd0);
    tick(); check_all("edge_rd");
    chk("edge_rd.value", m_valM, 64'hCAFEF00D12345678);

    // Seed a low region so random reads have known data
    for (int k = 0; k < 9; k++) begin
      drive(3'd1, 4'd4, 64'(8 * k), {8{8'(k + 1)}});
      tick(); check_all("seed");
    end

    // Stall holds for two cycles; stall with bubble loads a bubble
    drive(3'd1, 4'd6, 64'h1234, 64'h5678);
    e_dstE = 4'd3; e_Cnd = 1'b1;
    tick(); check_all("pre_stall");
    M_stall = 1'b1;
    drive(3'd2, 4'd2, 64'hAAAA, 64'hBBBB);
    tick(); check_all("stall1");
    chk("stall1.valE", M_valE, 64'h1234);
    drive(3'd4, 4'd7, 64'hCCCC, 64'hDDDD);
    tick(); check_all("stall2");
    chk("stall2.icode", 64'(M_icode), 64'd6);
    M_bubble = 1'b1;
    tick(); check_all("stall_bub");
    chk("stall_bub.icode", 64'(M_icode), 64'd1);
    chk("stall_bub.dstE", 64'(M_dstE), 64'd15);
    M_stall = 1'b0; M_bubble = 1'b0;

    // Reset squashes an AOK write sitting in M
    drive(3'd1, 4'd4, 64'h40, 64'hAAAAAAAAAAAAAAAA);
    tick(); check_all("sq_wr");
    reset = 1'b1;
    drive(3'd1, 4'd0, 64'd0, 64'd0);
    tick();
    chk("sq.icode", 64'(M_icode), 64'd1);
    reset = 1'b0;
    drive(3'd1, 4'd5, 64'h40, 64'd0);
    tick(); check_all("sq_rd");
    chk("sq_rd.value", m_valM, 64'h0909090909090909);

    // Randomised mix of instructions, statuses, addresses and pipeline controls
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [63:0] ad;
      r = int'($urandom_range(0, 9));
      if (r < 8) ad = 64'($urandom_range(0, 64));
      else if (r == 8) ad = 64'(MB - 8 + int'($urandom_range(0, 8)));
      else ad = {$urandom, $urandom};
      e_icode = 4'($urandom_range(0, 11));
      e_stat  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      e_Cnd   = 1'($urandom);
      e_dstE  = 4'($urandom);
      e_dstM  = 4'($urandom);
      if (e_icode == 4'd9 || e_icode == 4'd11) begin
        e_valA = ad; e_valE = {$urandom, $urandom};
      end else begin
        e_valE = ad; e_valA = {$urandom, $urandom};
      end
      M_stall  = ($urandom_range(0, 7) == 0);
      M_bubble = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 29) == 0);
      tick(); check_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
